// File: rtl/arb_defs.sv
`default_nettype none
// ============================================================================
// Module      : arb_defs (package)
// Description : Shared encodings for the memory port arbiter: FSM states,
//               transaction owner, grant-vector bit positions and the
//               byte-enable patterns used by sb / sh / sw.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_defs;

    // Arbiter FSM state (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arbState_t;

    // Which requester owns the bus transaction
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    // Bit positions inside the grant vector produced by arb_pick
    localparam int GNT_INST = 0;
    localparam int GNT_DATA = 1;

    // Streak counter width; holds the largest legal MAX_DATA_STREAK (15)
    localparam int STREAK_W = 4;

    // Byte-enable patterns for byte / half / word stores
    localparam logic [3:0] WEN_B = 4'b0001;
    localparam logic [3:0] WEN_H = 4'b0011;
    localparam logic [3:0] WEN_W = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational priority decision. Data wins unless fetch is
//               pending and data has already used up its streak allowance.
//               At most one grant bit is ever set.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import arb_defs::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                inst_req,
    input  logic                data_req,
    input  logic [STREAK_W-1:0] streak,
    output logic [1:0]          grant
);

    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic w_fetchDue;

    // Fetch is forced through once data has won C_STREAK_MAX times in a row
    always_comb begin
        w_fetchDue = inst_req && (streak == C_STREAK_MAX);
        grant      = 2'b00;
        if (data_req && !w_fetchDue) begin
            grant[GNT_DATA] = 1'b1;
        end else if (inst_req) begin
            grant[GNT_INST] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one SRAM-like bus master port between the fetch and
//               data requesters. One transaction in flight; data has priority
//               with a bounded streak so fetch cannot starve. Bus outputs come
//               only from registers latched at grant time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arb_defs::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch side
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    // data side
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    // bus master port
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    // stall hints for the hazard unit
    output logic              inst_busy,
    output logic              data_busy
);

    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arbState_t           r_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [3:0]          r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [STREAK_W-1:0] r_streak;

    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_done;

    arb_pick #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_pick (
        .inst_req (inst_req),
        .data_req (data_req),
        .streak   (r_streak),
        .grant    (w_grant)
    );

    // Address handshake and completion qualifiers; a bus_data_ok outside
    // ADDR/WAIT (e.g. a straggler after reset) never reaches a requester
    always_comb begin
        w_accept = bus_addr_ok && (r_state == ADDR);
        w_done   = bus_data_ok && ((r_state == WAIT) || w_accept);
    end

    // Arbitration FSM: grant latching, handshake tracking, streak counting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_NONE;
            r_addr   <= '0;
            r_wr     <= 1'b0;
            r_wen    <= 4'b0000;
            r_wdata  <= '0;
            r_streak <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant[GNT_DATA]) begin
                        r_owner <= OWN_DATA;
                        r_addr  <= data_addr;
                        r_wr    <= data_wr;
                        r_wen   <= data_wen;
                        r_wdata <= data_wdata;
                        r_state <= ADDR;
                    end else if (w_grant[GNT_INST]) begin
                        r_owner <= OWN_INST;
                        r_addr  <= inst_addr;
                        r_wr    <= 1'b0;
                        r_wen   <= 4'b0000;
                        r_wdata <= '0;
                        r_state <= ADDR;
                    end
                    // Streak only counts data wins that made fetch wait
                    if (!inst_req || w_grant[GNT_INST]) begin
                        r_streak <= '0;
                    end else if (w_grant[GNT_DATA] && (r_streak != C_STREAK_MAX)) begin
                        r_streak <= r_streak + 1'b1;
                    end
                end
                ADDR: begin
                    if (w_accept) begin
                        if (w_done) begin
                            r_state <= IDLE;
                            r_owner <= OWN_NONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        r_state <= IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Bus side is driven purely from the latched transaction
    always_comb begin
        bus_req   = (r_state == ADDR);
        bus_wr    = r_wr;
        bus_wen   = r_wen;
        bus_addr  = r_addr;
        bus_wdata = r_wdata;
    end

    // Handshake pulses steered to the owner only; read data fans out to both
    always_comb begin
        inst_addr_ok = w_accept && (r_owner == OWN_INST);
        data_addr_ok = w_accept && (r_owner == OWN_DATA);
        inst_data_ok = w_done   && (r_owner == OWN_INST);
        data_data_ok = w_done   && (r_owner == OWN_DATA);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
    end

    // Busy covers both the waiting request and the side's in-flight access
    always_comb begin
        inst_busy = inst_req || ((r_owner == OWN_INST) && (r_state != IDLE));
        data_busy = data_req || ((r_owner == OWN_DATA) && (r_state != IDLE));
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like bus master port between the fetch requester (pcF/instrF side) and the data requester (aluoutM_addr/writedataM/mem_wenM side).
- One transaction outstanding at a time.
- Data side has priority, bounded by an anti-starvation counter for fetch.
- Exports per-side busy flags that the hazard unit folds into stallF and stallM.

Parameters:
- ADDR_W, 32, address width for both requesters and the bus.
- DATA_W, 32, data width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending; fetch then wins the next arbitration. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  one-cycle pulse: fetch address accepted by the bus
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  DATA_W  fetched word
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_wen  in  4  byte enables (0001 / 0011 / 1111 for sb / sh / sw)
- data_addr  in  ADDR_W  word-aligned data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  one-cycle pulse: data address accepted
- data_data_ok  out  1  one-cycle pulse: load data valid / store complete
- data_rdata  out  DATA_W  load word
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_wen  out  4  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  bus accepted the address
- bus_data_ok  in  1  bus response valid
- bus_rdata  in  DATA_W  bus read data
- inst_busy  out  1  fetch request pending or in flight
- data_busy  out  1  data request pending or in flight

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - FSM goes to IDLE; streak counter = 0; owner = none; latched address/data/wen = 0.
  - bus_req, all *_ok, busy flags and bus_wr = 0; bus_wen = 0.
  - Reset mid-transaction abandons the transaction. A bus_data_ok arriving later in IDLE is ignored and pulses no requester.
- FSM states:
  - IDLE: no owner.
  - ADDR: bus_req=1, waiting for bus_addr_ok.
  - WAIT: address accepted, waiting for bus_data_ok.
- IDLE arbitration, evaluated each cycle:
  - Grant data if data_req && !(inst_req && streak==MAX_DATA_STREAK).
  - Otherwise grant inst if inst_req.
  - Otherwise stay IDLE.
- On grant:
  - Latch owner, addr, wr, wen, wdata into registers; next state ADDR.
  - bus_req rises the cycle after the grant (1-cycle arbitration latency).
  - Bus outputs come from registers only, never combinationally from requester inputs.
  - An inst grant forces bus_wr=0 and bus_wen=0000.
- Streak counter:
  - Increments on a data grant while inst_req=1; saturates at MAX_DATA_STREAK.
  - Clears on any inst grant, or when inst_req=0 in IDLE.
- ADDR state:
  - On bus_addr_ok: pulse the owner's *_addr_ok in the same cycle (combinational from bus_addr_ok && state==ADDR); next state WAIT.
  - If bus_data_ok is also 1 in that cycle: pulse the owner's *_data_ok too; next state IDLE.
- WAIT state:
  - bus_req=0.
  - On bus_data_ok: pulse the owner's *_data_ok; owner's rdata = bus_rdata in that cycle; next state IDLE.
  - The next grant can occur in that same IDLE cycle, giving back-to-back issue with one idle bus cycle between transactions.
- The non-owner's *_ok outputs stay 0 at all times; inst_rdata and data_rdata are driven from bus_rdata regardless of owner.
- busy flags:
  - inst_busy = inst_req || (owner==inst && state!=IDLE).
  - data_busy is the same for the data side.
  - Both are combinational.
- A requester that drops req before its grant is simply not granted; no error is raised.
- A request that changes address while not yet granted is legal, since latching happens only at grant.

Decomposition:
- Shared package `arb_defs`:
  - state encoding: IDLE=2'd0, ADDR=2'd1, WAIT=2'd2
  - owner encoding: OWN_NONE, OWN_INST, OWN_DATA
  - byte-enable constants WEN_B / WEN_H / WEN_W
- Sub-module `arb_pick`: the combinational priority and starvation decision. Inputs: inst_req, data_req, streak. Output: grant vector. This keeps it unit-testable.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; bus_addr_ok at cycle 2, bus_data_ok at cycle 4 with rdata 0x3C010001 -> inst_addr_ok pulses at cycle 2; inst_data_ok pulses at cycle 4 with inst_rdata=0x3C010001; bus_wr=0.
- Simultaneous requests at cycle 0 (inst 0x100; data store sw to 0x2000, wdata 0xDEADBEEF, wen 1111) -> data granted first with bus_wr=1, bus_wen=1111; fetch issued only after data_data_ok.
- Starvation, MAX_DATA_STREAK=4: data_req and inst_req held continuously -> exactly 4 data transactions, then 1 fetch, then data resumes.
- Same-cycle completion: bus_addr_ok and bus_data_ok both 1 in the first ADDR cycle of a load (rdata 0x000000FF) -> data_addr_ok and data_data_ok pulse together; FSM is back in IDLE next cycle.
- Reset in WAIT: rst=1 for one cycle during an outstanding fetch, then bus_data_ok=1 -> no inst_data_ok pulse; all outputs 0; next inst_req granted normally.
- Busy flags: data_req held with bus_addr_ok stalled for 5 cycles -> data_busy=1 throughout; inst_busy=0 while inst_req=0.
